// File: rtl/bg_prefetch.sv
// Background pixel prefetcher: streams SDRAM words into a FIFO, pops one pixel per active ce_pix (BG_PREFETCH_STATS_EN adds underrun_cnt).
// Latency: pop to bg_* is one clk_50 cycle; at most two SDRAM reads in flight.
// Backpressure: reads throttle on FIFO space plus reads in flight; an empty pop outputs zero and sets underrun.
module bg_prefetch #(
    parameter int DEPTH     = 8,
    parameter int ADDR_STEP = 2
) (
    input  logic        clk_50,
    input  logic        RESET_L,
    input  logic        ce_pix,
    input  logic        enable,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        vs,
    output logic        rd_req,
    output logic [24:0] rd_addr,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    output logic [3:0]  bg_r,
    output logic [3:0]  bg_g,
    output logic [3:0]  bg_b,
    output logic [3:0]  bg_a,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [24:0]   STEP_C  = 25'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;

    state_t        state, state_nxt;
    logic          vs_q;
    logic          vs_rise;
    logic [1:0]    outstanding;
    logic [AW:0]   fifo_count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   pix;

    logic          active_pix, do_flush, fetching, push, pop, pop_hit, dec, rd_req_nxt;
    logic [2:0]    in_flight;
    logic [AW+1:0] demand;

    assign vs_rise = ce_pix & vs & ~vs_q;

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable)
            state_nxt = IDLE;
        else if (vs_rise)
            state_nxt = FLUSH;
        else begin
            case (state)
                FLUSH:   if (outstanding == 2'd0) state_nxt = FILL;
                FILL:    if (fifo_count == DEPTH_C || (ce_pix && !hblank && !vblank)) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    // rd_req is registered, so the request already on the bus counts as in flight.
    always_comb begin
        active_pix = ce_pix & ~hblank & ~vblank;
        do_flush   = (state == FLUSH);
        fetching   = (state_nxt == FILL) || (state_nxt == RUN);
        push       = rd_valid && ((state == FILL) || (state == RUN));
        pop        = (state == RUN) && active_pix;
        pop_hit    = pop && (fifo_count != '0);
        dec        = rd_valid && (outstanding != 2'd0);
        in_flight  = {1'b0, outstanding} + {2'b00, rd_req};
        demand     = {1'b0, fifo_count} + {{(AW-1){1'b0}}, in_flight};
        rd_req_nxt = fetching && (in_flight < 3'd2) && (demand < DEPTH_W);
    end

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            vs_q        <= 1'b0;
            outstanding <= 2'd0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
        end else begin
            if (ce_pix) vs_q <= vs;
            case ({rd_req, dec})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
            rd_req <= rd_req_nxt;
            if (do_flush)    rd_addr <= '0;
            else if (rd_req) rd_addr <= rd_addr + STEP_C;
        end
    end

    // Responses outside FILL/RUN belong to a previous frame or reset epoch and are dropped.
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (do_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (pop_hit) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_hit})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (push && !do_flush) mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            pix      <= '0;
            underrun <= 1'b0;
        end else begin
            if (state_nxt != RUN) pix <= '0;
            else if (pop)         pix <= pop_hit ? mem[rd_ptr] : 16'h0000;
            if (do_flush)             underrun <= 1'b0;
            else if (pop && !pop_hit) underrun <= 1'b1;
        end
    end

    assign bg_b = pix[15:12];
    assign bg_a = pix[11:8];
    assign bg_r = pix[7:4];
    assign bg_g = pix[3:0];

`ifdef BG_PREFETCH_STATS_EN
    logic [15:0] ur_cnt;
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L)
            ur_cnt <= '0;
        else if (vs_rise && enable && underrun && ur_cnt != 16'hFFFF)
            ur_cnt <= ur_cnt + 16'd1;
    end
    assign underrun_cnt = ur_cnt;
`else
    assign underrun_cnt = 16'h0000;
`endif

    a_no_push_full: assert property (@(posedge clk_50) disable iff (!RESET_L)
        !(push && !do_flush && fifo_count == DEPTH_C));

endmodule

// File: tb/tb_bg_prefetch.sv
// Scoreboard bench for bg_prefetch: SDRAM model with configurable latency, in-order pixel checks.
module tb_bg_prefetch;
    localparam int DEPTH = 8;
    localparam int STEP  = 2;
`ifdef BG_PREFETCH_STATS_EN
    localparam logic [15:0] UR_CNT_EXP = 16'd1;
`else
    localparam logic [15:0] UR_CNT_EXP = 16'd0;
`endif

    logic        clk_50, RESET_L, ce_pix, enable, hblank, vblank, vs;
    logic        rd_req, rd_valid, underrun;
    logic [24:0] rd_addr;
    logic [15:0] rd_data, underrun_cnt;
    logic [3:0]  bg_r, bg_g, bg_b, bg_a;

    bg_prefetch #(.DEPTH(DEPTH), .ADDR_STEP(STEP)) dut (
        .clk_50(clk_50), .RESET_L(RESET_L), .ce_pix(ce_pix), .enable(enable),
        .hblank(hblank), .vblank(vblank), .vs(vs), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .bg_a(bg_a), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    typedef struct { logic [24:0] addr; int due; } req_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 3;
    int          zeros   = 0;
    logic [15:0] key     = 16'hA5C3;
    logic [24:0] sb_next_addr = '0;
    logic [15:0] last_pix = '0;
    logic [15:0] sb[$];
    logic [24:0] req_log[$];
    req_t        mq[$];
    req_t        mr;

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    function automatic logic [15:0] cur_pix();
        return {bg_b, bg_a, bg_r, bg_g};
    endfunction

    // SDRAM model: in-order responses, data = address ^ key; in-frame responses feed the scoreboard.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk_50);
            rd_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mr       = mq.pop_front();
                rd_valid = 1'b1;
                rd_data  = mr.addr[15:0] ^ key;
                if (mr.addr == sb_next_addr) begin
                    sb.push_back(rd_data);
                    sb_next_addr = sb_next_addr + 25'(STEP);
                end
            end
            if (rd_req) begin
                mr.addr = rd_addr;
                mr.due  = cyc + lat;
                mq.push_back(mr);
                req_log.push_back(rd_addr);
            end
            cyc++;
        end
    end

    task automatic vs_pulse();
        hblank = 1'b1; vblank = 1'b1;
        sb.delete();
        req_log.delete();
        sb_next_addr = '0;
        vs = 1'b1; ce_pix = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic pixel(input bit allow_ur);
        logic [15:0] got, exp;
        hblank = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
        got = cur_pix();
        if (allow_ur && got == 16'h0000) zeros++;
        else begin
            exp = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
            chk("pixel", 32'(got), 32'(exp));
        end
        last_pix = got;
    endtask

    task automatic wait_mq(input int n, input int budget, input string tag);
        int k = 0;
        while (mq.size() != n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(mq.size()), 32'(n));
    endtask

    initial begin
        RESET_L = 1'b0; ce_pix = 1'b0; enable = 1'b0;
        hblank = 1'b1; vblank = 1'b1; vs = 1'b0;
        #5;
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_pix", 32'(cur_pix()), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_ur_cnt", 32'(underrun_cnt), 0);
        tick(); tick();
        RESET_L = 1'b1;
        enable  = 1'b1;
        repeat (3) tick();
        chk("idle_no_req", 32'(req_log.size()), 0);

        // First frame: address sequence and fill to DEPTH.
        vs_pulse();
        repeat (60) tick();
        chk("fill_reqs", 32'(req_log.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            chk("rd_addr_seq", (i < req_log.size()) ? 32'(req_log[i]) : 32'hFFFF_FFFF, 32'(i * STEP));
        repeat (20) tick();
        chk("reqs_stop", 32'(req_log.size()), 32'(DEPTH));
        chk("pix_before_pop", 32'(cur_pix()), 0);

        // Head word 0xA5C3 split across the colour fields.
        pixel(1'b0);
        chk("bg_b", 32'(bg_b), 32'hA);
        chk("bg_a", 32'(bg_a), 32'h5);
        chk("bg_r", 32'(bg_r), 32'hC);
        chk("bg_g", 32'(bg_g), 32'h3);
        tick(); tick();
        chk("pix_hold", 32'(cur_pix()), 32'(last_pix));

        // Streaming with concurrent push/pop; order preserved over 64 words.
        for (int i = 0; i < 64; i++) begin
            pixel(1'b0);
            tick(); tick();
        end
        chk("no_underrun", 32'(underrun), 0);

        // New frame while two reads are in flight: their data must never surface.
        for (int i = 0; i < 40 && mq.size() != 2; i++) pixel(1'b0);
        chk("two_outstanding", 32'(mq.size()), 2);
        vs_pulse();
        repeat (60) tick();
        pixel(1'b0);
        chk("flush_first_pix", 32'(last_pix), 32'hA5C3);
        for (int i = 0; i < 6; i++) pixel(1'b0);

        // Slow SDRAM, fast pops: underrun, zero pixels, sticky flag and per-frame count.
        lat = 20;
        vs_pulse();
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            pixel(1'b1);
            tick();
        end
        chk("underrun_set", 32'(underrun), 1);
        chk("zero_pixels_seen", 32'(zeros > 5), 1);
        chk("ur_cnt_before_vs", 32'(underrun_cnt), 0);
        lat = 3;
        vs_pulse();
        chk("underrun_cleared", 32'(underrun), 0);
        chk("ur_cnt_after_vs", 32'(underrun_cnt), 32'(UR_CNT_EXP));
        repeat (80) tick();
        for (int i = 0; i < 8; i++) pixel(1'b0);
        chk("recover_no_underrun", 32'(underrun), 0);

        // enable low forces zero output and stops fetching.
        enable = 1'b0;
        tick(); tick();
        chk("disable_pix", 32'(cur_pix()), 0);
        chk("disable_rd_req", 32'(rd_req), 0);
        enable = 1'b1;
        vs_pulse();
        repeat (60) tick();
        for (int i = 0; i < 3; i++) pixel(1'b0);

        // Reset mid-run with reads in flight.
        for (int i = 0; i < 20 && mq.size() == 0; i++) pixel(1'b0);
        chk("inflight_before_reset", 32'(mq.size() > 0), 1);
        RESET_L = 1'b0;
        #1;
        chk("areset_pix", 32'(cur_pix()), 0);
        chk("areset_rd_req", 32'(rd_req), 0);
        chk("areset_rd_addr", 32'(rd_addr), 0);
        chk("areset_ur_cnt", 32'(underrun_cnt), 0);
        tick();
        RESET_L = 1'b1;
        wait_mq(0, 40, "late_rsp_drain");
        chk("post_reset_pix", 32'(cur_pix()), 0);
        chk("post_reset_rd_req", 32'(rd_req), 0);
        vs_pulse();
        repeat (60) tick();
        pixel(1'b0);
        chk("post_reset_first_pix", 32'(last_pix), 32'hA5C3);
        for (int i = 0; i < 8; i++) pixel(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
